updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
Parametrised synchronous up/down modulo-N counter. Supersedes the 4-bit ripple JK counter. Features:
- single clock domain, no rippled clocks;
- programmable modulus, reset preset value, parallel load and synchronous clear;
- wrap or saturate mode and a cascade carry.

Used as a general event counter, timer prescaler and BCD digit stage (MODULUS=10, chained via tc).

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2^WIDTH.
- RESET_VAL, 0, value of count after rst. Must be < MODULUS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  parallel load value.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sat_mode  in  1  end-of-range action: 1 = saturate, 0 = wrap.
- count  out  WIDTH  registered count value.
- tc  out  1  combinational terminal count / cascade carry.
- ovf  out  1  registered one-cycle overflow/underflow pulse.

Behaviour:
- Reset:
  - rst is synchronous, active-high; clock is clk.
  - On a rst edge: count = RESET_VAL, ovf = 0.
- Priority per rising edge: rst > clr > load > en. Exactly one action per cycle.
- clr: count <= 0, ovf <= 0.
- load:
  - count <= load_val if load_val < MODULUS, else count <= MODULUS-1 (clamped).
  - ovf <= 0. en is ignored in a load cycle.
- en=1, up_dn=1:
  - count < MODULUS-1: count <= count+1.
  - count = MODULUS-1, sat_mode=0: count <= 0, ovf <= 1.
  - count = MODULUS-1, sat_mode=1: count holds, ovf <= 1.
- en=1, up_dn=0:
  - count > 0: count <= count-1.
  - count = 0, sat_mode=0: count <= MODULUS-1, ovf <= 1.
  - count = 0, sat_mode=1: count holds at 0, ovf <= 1.
- en=0 (no rst/clr/load): count holds, ovf <= 0.
- ovf is high for exactly the one cycle after the boundary edge. Consecutive saturated attempts give back-to-back ovf pulses.
- tc = en & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
  - Purely combinational, no registered latency.
  - Intended to drive the en of the next cascaded stage in the same cycle.
- Latency: count updates on the edge after the control inputs are sampled (1 cycle). No internal state other than count and ovf.
- up_dn and sat_mode may change on any cycle. They take effect on the next edge.
- Comparisons are unsigned at WIDTH bits. MODULUS = 2^WIDTH must compile without overflow; compute bounds at WIDTH+1 bits.
- Simulation-only checks (no synthesis impact): MODULUS out of range, or RESET_VAL >= MODULUS, triggers an assertion/$error.

Optional Feature:
UPDOWN_COUNTER_GRAY_OUT_EN
- Defined:
  - Adds output port count_gray [WIDTH-1:0], registered, equal to the Gray code of the next count value: next ^ (next >> 1).
  - Updates in the same cycle as count, so count_gray always equals count ^ (count >> 1).
  - Reset value is the Gray code of RESET_VAL.
  - Only meaningful for glitch-free CDC when MODULUS = 2^WIDTH. For other moduli, single-bit change on wrap is not guaranteed; this is stated in the header comment.
- Undefined: port and register are absent. Behaviour otherwise identical.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted):
1. Reset then up-count: rst 1 cycle, then en=1, up_dn=1, sat_mode=0 for 12 cycles -> count 0,1,..,9,0,1,2. tc high while count=9. ovf high one cycle when count shows 0 after 9.
2. Down wrap: load load_val=1, then en=1, up_dn=0 for 3 cycles -> count 1,0,9,8. tc high at count=0. Single ovf pulse coincident with count=9.
3. Saturate: sat_mode=1, up_dn=1, load 8, en=1 for 4 cycles -> count 8,9,9,9. ovf=0 on the 8->9 step and 1 on each of the two held 9 cycles. Down from 0 holds 0 with ovf=1.
4. Priority/clamp:
   - same cycle rst=1, clr=1, load=1 -> count=RESET_VAL (rerun with RESET_VAL=5 -> 5);
   - clr=1 with load=1, load_val=7 -> count=0;
   - load=1, en=1, load_val=13 -> count=9 (clamped), no increment;
   - rst asserted mid-count at count=6 -> next count=0, ovf=0.
5. Cascade: two instances, MODULUS=10, stage1.en=stage0.tc, 105 enabled cycles from 0 -> {stage1,stage0}={0,5}. stage1 increments only on stage0 9->0 edges.
6. UPDOWN_COUNTER_GRAY_OUT_EN, WIDTH=4, MODULUS=16: up-count 0..15..0 -> count_gray == count^(count>>1) every cycle, exactly one bit toggles per step including 15->0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down modulo-MODULUS counter.
//
// Counts 0..MODULUS-1 in either direction, with a synchronous reset to RESET_VAL,
// a synchronous clear, a clamped parallel load, and a wrap or saturate choice at
// the ends of the range. tc is a same-cycle carry for cascading stages (feed it
// to the next stage's en). ovf is a registered one-cycle pulse that follows every
// enabled step that hits a range boundary, whether the count wraps or holds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (count <= RESET_VAL, ovf <= 0)
//   clr        synchronous clear to 0
//   load       parallel load strobe; load_val >= MODULUS clamps to MODULUS-1
//   load_val   parallel load value
//   en         count enable
//   up_dn      1 = count up, 0 = count down
//   sat_mode   1 = saturate at the boundary, 0 = wrap
//   count      registered count value
//   tc         combinational terminal count / cascade carry
//   ovf        registered overflow/underflow pulse
//   count_gray (only with UPDOWN_COUNTER_GRAY_OUT_EN) registered Gray code of count
//
// Priority per edge: rst > clr > load > en.
//
// Optional feature macro UPDOWN_COUNTER_GRAY_OUT_EN adds count_gray. A single-bit
// change on every step, including the wrap, is only guaranteed when
// MODULUS == 2**WIDTH. For other moduli the wrap can change several bits, so the
// output is not safe for CDC in that case.
module updown_mod_counter #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  // Bounds are held at WIDTH+1 bits so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   ModExt   = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   MaxExt   = ModExt - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MaxVal   = MaxExt[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ResetVal = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  if (WIDTH < 1 || WIDTH > 32) begin : gen_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : gen_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : gen_bad_reset_val
    $error("updown_mod_counter: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero, load_ok;

  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);
  assign load_ok = ({1'b0, load_val} < ModExt);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (rst) begin
      count_d = ResetVal;
    end else if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_ok ? load_val : MaxVal;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          ovf_d = 1'b1;
          if (!sat_mode) count_d = '0;
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          if (!sat_mode) count_d = MaxVal;
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  // tc ignores rst/clr/load on purpose: it only reflects en and the current count.
  assign tc    = en & ((up_dn & at_max) | (~up_dn & at_zero));

`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from count_d so the Gray value lands on the same edge as count.
  always_ff @(posedge clk) begin
    gray_q <= count_d ^ (count_d >> 1);
  end

  assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed vector table, random stimulus against a
// behavioural model, a two-stage decimal cascade and a full-range modulo-16 count.
module tb_updown_mod_counter;

  localparam int M = 10;

  typedef struct {
    bit rst, clr, load;
    int lv;
    bit en, up, sat;
    int cnt;
    bit ovf;
    bit tc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for dut_a (RESET_VAL=0) and dut_b (RESET_VAL=5).
  logic       rst, clr, load, en, up_dn, sat_mode;
  logic [3:0] load_val;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  // Cascade and full-range instances.
  logic       crst, cen, grst, gen;
  logic [3:0] cnt_c0, cnt_c1, cnt_g;
  logic       tc_c0, tc_c1, ovf_c0, ovf_c1, tc_g, ovf_g;

`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
  logic [3:0] gray_a, gray_b, gray_c0, gray_c1, gray_g;
`endif

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .count(cnt_a), .tc(tc_a), .ovf(ovf_a)
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    , .count_gray(gray_a)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode), .count(cnt_b), .tc(tc_b), .ovf(ovf_b)
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    , .count_gray(gray_b)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_c0 (
    .clk(clk), .rst(crst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(cen),
    .up_dn(1'b1), .sat_mode(1'b0), .count(cnt_c0), .tc(tc_c0), .ovf(ovf_c0)
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    , .count_gray(gray_c0)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_c1 (
    .clk(clk), .rst(crst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(tc_c0),
    .up_dn(1'b1), .sat_mode(1'b0), .count(cnt_c1), .tc(tc_c1), .ovf(ovf_c1)
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    , .count_gray(gray_c1)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_g (
    .clk(clk), .rst(grst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(gen),
    .up_dn(1'b1), .sat_mode(1'b0), .count(cnt_g), .tc(tc_g), .ovf(ovf_g)
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    , .count_gray(gray_g)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ma = 0;
  int   mb = 0;
  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic void add(bit r, bit c, bit l, int lv, bit e, bit u, bit s,
                              int cnt, bit o, bit t);
    vec_t v;
    v.rst = r; v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u; v.sat = s;
    v.cnt = cnt; v.ovf = o; v.tc = t;
    tab.push_back(v);
  endfunction

  // Reference model: step to m+/-1; leaving 0..M-1 raises ovf and either holds or
  // folds back into range modulo M.
  function automatic int nxt(int m, int rv, vec_t v, output bit o);
    int t;
    o = 1'b0;
    if (v.rst) return rv;
    if (v.clr) return 0;
    if (v.load) return (v.lv < M) ? v.lv : M - 1;
    if (!v.en) return m;
    t = v.up ? m + 1 : m - 1;
    if (t < 0 || t >= M) begin
      o = 1'b1;
      return v.sat ? m : (t + M) % M;
    end
    return t;
  endfunction

  function automatic bit model_tc(int m, vec_t v);
    return v.en && (v.up ? (m == M - 1) : (m == 0));
  endfunction

  // One clock: drive, check tc before the edge, check count/ovf after it.
  // With use_tab set, dut_a is held to the table's hand-written expectations.
  task automatic step(input vec_t v, input bit use_tab);
    bit oa, ob;
    int na, nb;
    rst = v.rst; clr = v.clr; load = v.load; load_val = 4'(v.lv);
    en = v.en; up_dn = v.up; sat_mode = v.sat;
    #1;
    chk("tc_a", 32'(tc_a), 32'(use_tab ? v.tc : model_tc(ma, v)));
    chk("tc_b", 32'(tc_b), 32'(model_tc(mb, v)));
    na = nxt(ma, 0, v, oa);
    nb = nxt(mb, 5, v, ob);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    chk("count_a", 32'(cnt_a), 32'(use_tab ? v.cnt : ma));
    chk("ovf_a", 32'(ovf_a), 32'(use_tab ? v.ovf : oa));
    chk("count_b", 32'(cnt_b), 32'(mb));
    chk("ovf_b", 32'(ovf_b), 32'(ob));
  endtask

  initial begin
    vec_t v;
    int   k, prev_g;
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    crst = 1'b0; cen = 1'b0; grst = 1'b0; gen = 1'b0;

    //  rst clr load lv  en up sat  cnt ovf tc
    // Reset, then up-count through the wrap.
    add(1, 0, 0, 0,   0, 1, 0,   0, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 0, 0, 0, 1, 1, 0, (i + 1) % 10, i == 9, i == 9);
    // Down wrap after load 1.
    add(0, 0, 1, 1,   0, 0, 0,   1, 0, 0);
    add(0, 0, 0, 0,   1, 0, 0,   0, 0, 0);
    add(0, 0, 0, 0,   1, 0, 0,   9, 1, 1);
    add(0, 0, 0, 0,   1, 0, 0,   8, 0, 0);
    // Saturate up at 9, then saturate down at 0.
    add(0, 0, 1, 8,   0, 1, 1,   8, 0, 0);
    add(0, 0, 0, 0,   1, 1, 1,   9, 0, 0);
    add(0, 0, 0, 0,   1, 1, 1,   9, 1, 1);
    add(0, 0, 0, 0,   1, 1, 1,   9, 1, 1);
    add(0, 1, 0, 0,   0, 0, 1,   0, 0, 0);
    add(0, 0, 0, 0,   1, 0, 1,   0, 1, 1);
    add(0, 0, 0, 0,   1, 0, 1,   0, 1, 1);
    add(0, 0, 0, 0,   0, 0, 1,   0, 0, 0);
    // Priority and clamp.
    add(1, 1, 1, 7,   0, 1, 0,   0, 0, 0);
    add(0, 1, 1, 7,   1, 1, 0,   0, 0, 0);
    add(0, 0, 1, 13,  1, 1, 0,   9, 0, 0);
    add(0, 0, 1, 5,   0, 1, 0,   5, 0, 0);
    add(0, 0, 0, 0,   1, 1, 0,   6, 0, 0);
    add(1, 0, 0, 0,   1, 1, 0,   0, 0, 0);
    add(0, 0, 1, 9,   0, 1, 1,   9, 0, 0);
    add(1, 0, 0, 0,   1, 1, 1,   0, 0, 1);
    add(0, 1, 0, 0,   1, 0, 1,   0, 0, 1);
    add(0, 0, 1, 9,   0, 1, 0,   9, 0, 0);
    add(0, 0, 0, 0,   0, 1, 0,   9, 0, 0);
    add(0, 0, 1, 3,   1, 1, 0,   3, 0, 1);

    foreach (tab[i]) step(tab[i], 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v.rst  = ($urandom % 32) == 0;
      v.clr  = ($urandom % 16) == 0;
      v.load = ($urandom % 8) == 0;
      v.lv   = int'($urandom % 16);
      v.en   = ($urandom % 4) != 0;
      v.up   = 1'($urandom);
      v.sat  = ($urandom % 4) == 0;
      v.cnt  = 0; v.ovf = 1'b0; v.tc = 1'b0;
      step(v, 1'b0);
    end

    // Two-stage decimal cascade: 105 enabled cycles from 0.
    crst = 1'b1;
    @(posedge clk);
    #1;
    crst = 1'b0;
    chk("cascade_rst_c0", 32'(cnt_c0), 32'd0);
    chk("cascade_rst_c1", 32'(cnt_c1), 32'd0);
    cen = 1'b1;
    for (int i = 1; i <= 105; i++) begin
      #1;
      chk("cascade_tc0", 32'(tc_c0), 32'(((i - 1) % 10) == 9));
      @(posedge clk);
      #1;
      chk("cascade_c0", 32'(cnt_c0), 32'(i % 10));
      chk("cascade_c1", 32'(cnt_c1), 32'((i / 10) % 10));
    end
    cen = 1'b0;
    chk("cascade_final", 32'({cnt_c1, cnt_c0}), 32'h05);

    // Full-range modulo-16 count, 0..15..0.
    grst = 1'b1;
    @(posedge clk);
    #1;
    grst = 1'b0;
    chk("full_rst", 32'(cnt_g), 32'd0);
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    chk("gray_rst", 32'(gray_g), 32'd0);
`endif
    prev_g = 0;
    gen = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      k = i % 16;
      chk("full_count", 32'(cnt_g), 32'(k));
      chk("full_ovf", 32'(ovf_g), 32'(i == 16));
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
      chk("gray_value", 32'(gray_g), 32'(k ^ (k >> 1)));
      chk("gray_one_bit", 32'($countones(gray_g ^ 4'(prev_g))), 32'd1);
      prev_g = k ^ (k >> 1);
`endif
    end
    gen = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
